ahbl_arbiter: RTL and testbench

AHB-lite N:1 arbiter that merges N upstream masters onto one downstream slave port. It is the counterpart of the 1:N address-decoding splitter, and the two combine into a full crossbar. The arbiter buffers the address phase of any master that loses arbitration and stalls that master until its buffered transfer completes downstream. It forwards exclusive-access signalling (hexcl/hmaster/hexokay).

---
 rtl/ahbl_arbiter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ahbl_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_arbiter : AHB-lite N:1 arbiter.
// Merges N_PORTS upstream masters onto one downstream slave port. A master
// that loses arbitration has its address phase buffered and is stalled (its
// hready_resp low) until the buffered transfer is issued downstream.
// Exclusive-access sideband (hexcl/hmaster/hexokay) is forwarded.
//
// Build option: define AHBL_ARBITER_ROUND_ROBIN_EN to make the unlocked grant
// round-robin (search starts after the last granted port). Without it the
// lowest-index requesting port wins.
//
// Handshake: an address phase is accepted downstream on a rising clk edge
// where dst_htrans=NONSEQ and dst_hready_resp=1; the data phase of that
// transfer completes on the next edge with dst_hready_resp=1. Upstream port i
// sees src_hready_resp[i], which is the downstream ready while it owns the
// data phase, 0 while its address phase sits in the buffer, and 1 otherwise.
// ---------------------------------------------------------------------------
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          src_hready,
    output logic [N_PORTS-1:0]          src_hready_resp,
    output logic [N_PORTS-1:0]          src_hresp,
    input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS-1:0]          src_hwrite,
    input  logic [N_PORTS*2-1:0]        src_htrans,
    input  logic [N_PORTS*3-1:0]        src_hsize,
    input  logic [N_PORTS*3-1:0]        src_hburst,
    input  logic [N_PORTS*4-1:0]        src_hprot,
    input  logic [N_PORTS-1:0]          src_hmastlock,
    input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
    output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
    input  logic [N_PORTS-1:0]          src_hexcl,
    input  logic [N_PORTS*8-1:0]        src_hmaster,
    output logic [N_PORTS-1:0]          src_hexokay,
    output logic                        dst_hready,
    input  logic                        dst_hready_resp,
    input  logic                        dst_hresp,
    output logic [W_ADDR-1:0]           dst_haddr,
    output logic                        dst_hwrite,
    output logic [1:0]                  dst_htrans,
    output logic [2:0]                  dst_hsize,
    output logic [2:0]                  dst_hburst,
    output logic [3:0]                  dst_hprot,
    output logic                        dst_hmastlock,
    output logic                        dst_hexcl,
    output logic [7:0]                  dst_hmaster,
    output logic [W_DATA-1:0]           dst_hwdata,
    input  logic [W_DATA-1:0]           dst_hrdata,
    input  logic                        dst_hexokay
);

    localparam int         W_IDX         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Per-port address-phase buffers
    logic [N_PORTS-1:0] r_buf_valid;
    logic [W_ADDR-1:0]  r_buf_addr   [N_PORTS];
    logic               r_buf_write  [N_PORTS];
    logic [2:0]         r_buf_size   [N_PORTS];
    logic [3:0]         r_buf_prot   [N_PORTS];
    logic               r_buf_lock   [N_PORTS];
    logic               r_buf_excl   [N_PORTS];
    logic [7:0]         r_buf_master [N_PORTS];

    // Data-phase owner (one-hot) and bus lock state
    logic [N_PORTS-1:0] r_sel_d;
    logic               r_lock;
    logic [W_IDX-1:0]   r_lock_idx;

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
    logic [W_IDX-1:0]   r_rr_ptr;
`endif

    logic [N_PORTS-1:0] w_new_req;
    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_gnt;
    logic [N_PORTS-1:0] w_clear;
    logic [N_PORTS-1:0] w_capture;
    logic               w_any_gnt;
    logic [W_IDX-1:0]   w_gnt_idx;
    logic               w_accept;

    logic [W_ADDR-1:0]  w_a_addr;
    logic               w_a_write;
    logic [2:0]         w_a_size;
    logic [3:0]         w_a_prot;
    logic               w_a_lock;
    logic               w_a_excl;
    logic [7:0]         w_a_master;

    // Only htrans[1] and nothing of hburst carries meaning here.
    logic [N_PORTS-1:0] w_htrans_lo;
    logic               w_unused;

    // New request decode and combined request vector
    always_comb begin
        w_new_req   = '0;
        w_htrans_lo = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_new_req[i]   = src_htrans[2*i+1] & src_hready[i];
            w_htrans_lo[i] = src_htrans[2*i];
        end
        w_req = r_buf_valid | w_new_req;
    end

    assign w_unused = ^{src_hburst, w_htrans_lo};

    // Grant selection: locked owner only, otherwise priority / round-robin
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_any_gnt = 1'b0;
        w_gnt_idx = '0;
        if (r_lock) begin
            if (w_req[r_lock_idx]) begin
                w_any_gnt = 1'b1;
                w_gnt_idx = r_lock_idx;
            end
        end else begin
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
            for (int k = 1; k <= N_PORTS; k++) begin
                v_idx = int'(r_rr_ptr) + k;
                if (v_idx >= N_PORTS) begin
                    v_idx = v_idx - N_PORTS;
                end
                if (!w_any_gnt && w_req[v_idx[W_IDX-1:0]]) begin
                    w_any_gnt = 1'b1;
                    w_gnt_idx = v_idx[W_IDX-1:0];
                end
            end
`else
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (w_req[i]) begin
                    w_any_gnt = 1'b1;
                    w_gnt_idx = W_IDX'(i);
                end
            end
`endif
        end
        w_gnt = '0;
        if (w_any_gnt) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_accept  = dst_hready_resp & w_any_gnt;
    assign w_clear   = w_gnt & {N_PORTS{dst_hready_resp}};
    assign w_capture = w_new_req & ~w_clear;

    // Address-phase source for the granted port: buffer if held, else live
    always_comb begin
        w_a_addr   = '0;
        w_a_write  = 1'b0;
        w_a_size   = '0;
        w_a_prot   = '0;
        w_a_lock   = 1'b0;
        w_a_excl   = 1'b0;
        w_a_master = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_any_gnt && (w_gnt_idx == W_IDX'(i))) begin
                if (r_buf_valid[i]) begin
                    w_a_addr   = r_buf_addr[i];
                    w_a_write  = r_buf_write[i];
                    w_a_size   = r_buf_size[i];
                    w_a_prot   = r_buf_prot[i];
                    w_a_lock   = r_buf_lock[i];
                    w_a_excl   = r_buf_excl[i];
                    w_a_master = r_buf_master[i];
                end else begin
                    w_a_addr   = src_haddr[i*W_ADDR +: W_ADDR];
                    w_a_write  = src_hwrite[i];
                    w_a_size   = src_hsize[i*3 +: 3];
                    w_a_prot   = src_hprot[i*4 +: 4];
                    w_a_lock   = src_hmastlock[i];
                    w_a_excl   = src_hexcl[i];
                    w_a_master = src_hmaster[i*8 +: 8];
                end
            end
        end
    end

    // Downstream address phase; SEQ and bursts collapse to single NONSEQ
    assign dst_htrans    = w_any_gnt ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign dst_haddr     = w_a_addr;
    assign dst_hwrite    = w_a_write;
    assign dst_hsize     = w_a_size;
    assign dst_hburst    = HBURST_SINGLE;
    assign dst_hprot     = w_a_prot;
    assign dst_hmastlock = w_any_gnt & w_a_lock;
    assign dst_hexcl     = w_a_excl;
    assign dst_hmaster   = w_a_master;
    assign dst_hready    = dst_hready_resp;

    // Buffer capture of losing/stalled requests, release on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                r_buf_addr[i]   <= '0;
                r_buf_write[i]  <= 1'b0;
                r_buf_size[i]   <= '0;
                r_buf_prot[i]   <= '0;
                r_buf_lock[i]   <= 1'b0;
                r_buf_excl[i]   <= 1'b0;
                r_buf_master[i] <= '0;
            end
        end else begin
            r_buf_valid <= (r_buf_valid & ~w_clear) | w_capture;
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_capture[i]) begin
                    r_buf_addr[i]   <= src_haddr[i*W_ADDR +: W_ADDR];
                    r_buf_write[i]  <= src_hwrite[i];
                    r_buf_size[i]   <= src_hsize[i*3 +: 3];
                    r_buf_prot[i]   <= src_hprot[i*4 +: 4];
                    r_buf_lock[i]   <= src_hmastlock[i];
                    r_buf_excl[i]   <= src_hexcl[i];
                    r_buf_master[i] <= src_hmaster[i*8 +: 8];
                end
            end
        end
    end

    // Data-phase owner follows the grant whenever the slave is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_d <= '0;
        end else if (dst_hready_resp) begin
            r_sel_d <= w_gnt;
        end
    end

    // Lock tracks hmastlock of every accepted address phase; while set only
    // the owner can be granted, so the owner's unlocked transfer releases it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_accept) begin
            r_lock     <= w_a_lock;
            r_lock_idx <= w_gnt_idx;
        end
    end

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
    // Round-robin pointer: last granted port, starts so port 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= W_IDX'(N_PORTS - 1);
        end else if (w_accept) begin
            r_rr_ptr <= w_gnt_idx;
        end
    end
`endif

    // Upstream responses: owner sees the slave, buffered port is stalled
    assign src_hready_resp = (r_sel_d & {N_PORTS{dst_hready_resp}}) | (~r_sel_d & ~r_buf_valid);
    assign src_hresp       = r_sel_d & {N_PORTS{dst_hresp}};
    assign src_hexokay     = r_sel_d & {N_PORTS{dst_hexokay}};
    assign src_hrdata      = {N_PORTS{dst_hrdata}};

    // Write data comes from the data-phase owner
    always_comb begin
        dst_hwdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_sel_d[i]) begin
                dst_hwdata = dst_hwdata | src_hwdata[i*W_DATA +: W_DATA];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahbl_arbiter : directed testbench for ahbl_arbiter (2 ports, 32/32).
// Inputs are driven on the falling clock edge and outputs sampled 1 ns later.
// Masters' hready is tied to the arbiter's hready_resp, as at fabric top.
// ---------------------------------------------------------------------------
module tb_ahbl_arbiter;

    localparam int N  = 2;
    localparam int WA = 32;
    localparam int WD = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      src_hready;
    logic [N-1:0]      src_hready_resp;
    logic [N-1:0]      src_hresp;
    logic [N*WA-1:0]   src_haddr;
    logic [N-1:0]      src_hwrite;
    logic [N*2-1:0]    src_htrans;
    logic [N*3-1:0]    src_hsize;
    logic [N*3-1:0]    src_hburst;
    logic [N*4-1:0]    src_hprot;
    logic [N-1:0]      src_hmastlock;
    logic [N*WD-1:0]   src_hwdata;
    logic [N*WD-1:0]   src_hrdata;
    logic [N-1:0]      src_hexcl;
    logic [N*8-1:0]    src_hmaster;
    logic [N-1:0]      src_hexokay;
    logic              dst_hready;
    logic              dst_hready_resp;
    logic              dst_hresp;
    logic [WA-1:0]     dst_haddr;
    logic              dst_hwrite;
    logic [1:0]        dst_htrans;
    logic [2:0]        dst_hsize;
    logic [2:0]        dst_hburst;
    logic [3:0]        dst_hprot;
    logic              dst_hmastlock;
    logic              dst_hexcl;
    logic [7:0]        dst_hmaster;
    logic [WD-1:0]     dst_hwdata;
    logic [WD-1:0]     dst_hrdata;
    logic              dst_hexokay;

    int n_vec = 0;
    int n_err = 0;
    logic [WA-1:0] exp_q[$];

    assign src_hready = src_hready_resp;

    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
        .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hexcl(dst_hexcl), .dst_hmaster(dst_hmaster),
        .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata), .dst_hexokay(dst_hexokay)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master address-phase driver
    task automatic m_set(input int p, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic lk);
        src_htrans[p*2 +: 2]  = tr;
        src_haddr[p*WA +: WA] = a;
        src_hwrite[p]         = wr;
        src_hmastlock[p]      = lk;
    endtask

    task automatic m_idle(input int p);
        m_set(p, IDLE, 32'h0, 1'b0, 1'b0);
    endtask

    // Scoreboard: every accepted downstream address phase must match the
    // next expected address, in order
    always begin
        @(negedge clk);
        #2;
        if (rst_n && dst_hready_resp && dst_htrans == NONSEQ) begin
            check("addr_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("addr_order", 64'(dst_haddr), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        src_haddr       = '0;
        src_hwrite      = '0;
        src_htrans      = '0;
        src_hsize       = {3'b010, 3'b010};
        src_hburst      = {3'b011, 3'b011};
        src_hprot       = {4'b0011, 4'b0011};
        src_hmastlock   = '0;
        src_hwdata      = '0;
        src_hexcl       = '0;
        src_hmaster     = {8'h01, 8'h00};
        dst_hready_resp = 1'b1;
        dst_hresp       = 1'b0;
        dst_hrdata      = '0;
        dst_hexokay     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_hready_resp", 64'(src_hready_resp), 64'h3);
        check("rst_hresp", 64'(src_hresp), 64'h0);
        check("rst_hexokay", 64'(src_hexokay), 64'h0);
        check("rst_htrans", 64'(dst_htrans), 64'(IDLE));
        check("rst_mastlock", 64'(dst_hmastlock), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single master: port1 read, zero stall, exclusive sideband
        @(negedge clk);
        m_set(1, NONSEQ, 32'h2000_0010, 1'b0, 1'b0);
        src_hexcl[1]       = 1'b1;
        src_hmaster[15:8]  = 8'h21;
        exp_q.push_back(32'h2000_0010);
        #1;
        check("t1_haddr", 64'(dst_haddr), 64'h2000_0010);
        check("t1_htrans", 64'(dst_htrans), 64'(NONSEQ));
        check("t1_hburst", 64'(dst_hburst), 64'h0);
        check("t1_hexcl", 64'(dst_hexcl), 64'h1);
        check("t1_hmaster", 64'(dst_hmaster), 64'h21);
        check("t1_rdy_a", 64'(src_hready_resp[1]), 64'h1);
        @(negedge clk);
        m_idle(1);
        src_hexcl[1] = 1'b0;
        dst_hrdata   = 32'hDEAD_BEEF;
        dst_hexokay  = 1'b1;
        #1;
        check("t1_rdata", 64'(src_hrdata[63:32]), 64'hDEAD_BEEF);
        check("t1_rdy_d", 64'(src_hready_resp[1]), 64'h1);
        check("t1_exokay", 64'(src_hexokay), 64'h2);
        check("t1_idle", 64'(dst_htrans), 64'(IDLE));

        // Contention: port0 first, port1 buffered then issued
        @(negedge clk);
        dst_hexokay = 1'b0;
        m_set(0, NONSEQ, 32'h100, 1'b0, 1'b0);
        m_set(1, NONSEQ, 32'h200, 1'b0, 1'b0);
        exp_q.push_back(32'h100);
        #1;
        check("t2_first", 64'(dst_haddr), 64'h100);
        @(negedge clk);
        m_idle(0);
        dst_hrdata = 32'h1111_0000;
        exp_q.push_back(32'h200);
        #1;
        check("t2_stall1", 64'(src_hready_resp[1]), 64'h0);
        check("t2_second", 64'(dst_haddr), 64'h200);
        check("t2_rdy0", 64'(src_hready_resp[0]), 64'h1);
        check("t2_rdata0", 64'(src_hrdata[31:0]), 64'h1111_0000);
        @(negedge clk);
        m_idle(1);
        dst_hrdata = 32'h2222_0000;
        #1;
        check("t2_rdy1", 64'(src_hready_resp[1]), 64'h1);
        check("t2_rdata1", 64'(src_hrdata[63:32]), 64'h2222_0000);
        check("t2_idle", 64'(dst_htrans), 64'(IDLE));

        // Wait states during port0 write; port1 arrives mid-stall
        @(negedge clk);
        m_set(0, NONSEQ, 32'h300, 1'b1, 1'b0);
        exp_q.push_back(32'h300);
        #1;
        check("t3_wr", 64'(dst_hwrite), 64'h1);
        @(negedge clk);
        m_idle(0);
        src_hwdata[31:0] = 32'hCAFE_F00D;
        dst_hready_resp  = 1'b0;
        #1;
        check("t3_wd_b", 64'(dst_hwdata), 64'hCAFE_F00D);
        check("t3_rdy0_b", 64'(src_hready_resp[0]), 64'h0);
        @(negedge clk);
        m_set(1, NONSEQ, 32'h400, 1'b0, 1'b0);
        #1;
        check("t3_wd_c", 64'(dst_hwdata), 64'hCAFE_F00D);
        check("t3_rdy1_c", 64'(src_hready_resp[1]), 64'h1);
        @(negedge clk);
        #1;
        check("t3_wd_d", 64'(dst_hwdata), 64'hCAFE_F00D);
        check("t3_stall1", 64'(src_hready_resp[1]), 64'h0);
        check("t3_bufaddr", 64'(dst_haddr), 64'h400);
        @(negedge clk);
        dst_hready_resp = 1'b1;
        exp_q.push_back(32'h400);
        #1;
        check("t3_wd_e", 64'(dst_hwdata), 64'hCAFE_F00D);
        check("t3_rdy0_e", 64'(src_hready_resp[0]), 64'h1);
        check("t3_issue", 64'(dst_haddr), 64'h400);
        @(negedge clk);
        m_idle(1);
        dst_hrdata = 32'h4444_0000;
        #1;
        check("t3_rdy1_f", 64'(src_hready_resp[1]), 64'h1);
        check("t3_rdata", 64'(src_hrdata[63:32]), 64'h4444_0000);

        // Two-cycle error response to port1
        @(negedge clk);
        m_set(1, NONSEQ, 32'h500, 1'b0, 1'b0);
        exp_q.push_back(32'h500);
        @(negedge clk);
        m_idle(1);
        dst_hresp       = 1'b1;
        dst_hready_resp = 1'b0;
        #1;
        check("t4_hresp1_a", 64'(src_hresp[1]), 64'h1);
        check("t4_rdy1_a", 64'(src_hready_resp[1]), 64'h0);
        check("t4_hresp0_a", 64'(src_hresp[0]), 64'h0);
        check("t4_rdy0_a", 64'(src_hready_resp[0]), 64'h1);
        @(negedge clk);
        dst_hready_resp = 1'b1;
        #1;
        check("t4_hresp1_b", 64'(src_hresp[1]), 64'h1);
        check("t4_rdy1_b", 64'(src_hready_resp[1]), 64'h1);
        check("t4_hresp0_b", 64'(src_hresp[0]), 64'h0);
        @(negedge clk);
        dst_hresp = 1'b0;
        #1;
        check("t4_hresp1_c", 64'(src_hresp[1]), 64'h0);

        // Locked read-modify-write by port1 while port0 keeps requesting
        @(negedge clk);
        m_set(1, NONSEQ, 32'h600, 1'b0, 1'b1);
        exp_q.push_back(32'h600);
        #1;
        check("t5_lock_a", 64'(dst_hmastlock), 64'h1);
        @(negedge clk);
        m_set(1, SEQ, 32'h600, 1'b1, 1'b1);
        m_set(0, NONSEQ, 32'h700, 1'b0, 1'b0);
        dst_hrdata = 32'h6666_0000;
        exp_q.push_back(32'h600);
        #1;
        check("t5_seq_as_nonseq", 64'(dst_htrans), 64'(NONSEQ));
        check("t5_owner_addr", 64'(dst_haddr), 64'h600);
        check("t5_owner_wr", 64'(dst_hwrite), 64'h1);
        check("t5_rdata", 64'(src_hrdata[63:32]), 64'h6666_0000);
        @(negedge clk);
        m_idle(1);
        src_hwdata[63:32] = 32'h6666_0001;
        #1;
        check("t5_hold_idle", 64'(dst_htrans), 64'(IDLE));
        check("t5_stall0_c", 64'(src_hready_resp[0]), 64'h0);
        check("t5_wdata", 64'(dst_hwdata), 64'h6666_0001);
        @(negedge clk);
        m_set(1, NONSEQ, 32'h610, 1'b0, 1'b0);
        exp_q.push_back(32'h610);
        #1;
        check("t5_unlock_addr", 64'(dst_haddr), 64'h610);
        check("t5_unlock_ml", 64'(dst_hmastlock), 64'h0);
        check("t5_stall0_d", 64'(src_hready_resp[0]), 64'h0);
        @(negedge clk);
        m_idle(1);
        exp_q.push_back(32'h700);
        #1;
        check("t5_p0_issue", 64'(dst_haddr), 64'h700);
        @(negedge clk);
        m_idle(0);
        #1;
        check("t5_rdy0_f", 64'(src_hready_resp[0]), 64'h1);
        check("t5_idle", 64'(dst_htrans), 64'(IDLE));

        // Reset while port0 is buffered
        @(negedge clk);
        m_set(1, NONSEQ, 32'h900, 1'b0, 1'b0);
        exp_q.push_back(32'h900);
        @(negedge clk);
        m_idle(1);
        dst_hready_resp = 1'b0;
        m_set(0, NONSEQ, 32'h800, 1'b0, 1'b0);
        #1;
        check("t6_stall1", 64'(src_hready_resp[1]), 64'h0);
        @(negedge clk);
        #1;
        check("t6_buffered", 64'(src_hready_resp[0]), 64'h0);
        check("t6_bufaddr", 64'(dst_haddr), 64'h800);
        m_idle(0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_htrans", 64'(dst_htrans), 64'(IDLE));
        check("t6_rst_rdy", 64'(src_hready_resp), 64'h3);
        check("t6_rst_hresp", 64'(src_hresp), 64'h0);
        check("t6_rst_ml", 64'(dst_hmastlock), 64'h0);
        @(negedge clk);
        rst_n           = 1'b1;
        dst_hready_resp = 1'b1;
        #1;
        check("t6_post_idle", 64'(dst_htrans), 64'(IDLE));
        check("t6_post_rdy", 64'(src_hready_resp), 64'h3);

        check("q_drain", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
